atm_dispense_ctrl: RTL and testbench



---
 rtl/atm_dispense_ctrl_if.sv | 27 ++
 rtl/atm_dispense_ctrl.sv | 148 ++++++++++++++
 tb/tb_atm_dispense_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_dispense_ctrl_if.sv
// atm_dispense_ctrl_if: request/status bundle between the PIN FSM side and the note dispenser sequencer.
//   master: drives req, amount, taken, refill; observes busy, motor, done, err_stock, retracted, stock, state_dbg
//   slave : the dispenser sequencer (atm_dispense_ctrl)
interface atm_dispense_ctrl_if #(
    parameter int NOTE_BITS  = 3,
    parameter int STOCK_BITS = 8
);
    logic                  req;
    logic [NOTE_BITS-1:0]  amount;
    logic                  taken;
    logic                  refill;
    logic                  busy;
    logic                  motor;
    logic                  done;
    logic                  err_stock;
    logic                  retracted;
    logic [STOCK_BITS-1:0] stock;
    logic [2:0]            state_dbg;
    modport master (
        output req, amount, taken, refill,
        input  busy, motor, done, err_stock, retracted, stock, state_dbg
    );
    modport slave (
        input  req, amount, taken, refill,
        output busy, motor, done, err_stock, retracted, stock, state_dbg
    );
endinterface

// File: rtl/atm_dispense_ctrl.sv
// atm_dispense_ctrl: sequences note dispensing (stock check, motor pulses, present, optional timeout retract).
//   clk_2 : clock, all registers update on its rising edge
//   reset : synchronous active-high reset
//   bus   : atm_dispense_ctrl_if.slave (req/amount/taken/refill in; busy/motor/done/err_stock/retracted/stock/state_dbg out)
//   Macro ATM_RETRACT_EN enables the PRESENT timeout and the RETRACT state; without it PRESENT waits forever.
module atm_dispense_ctrl #(
    parameter int NOTE_BITS   = 3,
    parameter int STOCK_BITS  = 8,
    parameter int STOCK_INIT  = 20,
    parameter int PULSE_CYC   = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input logic clk_2,
    input logic reset,
    atm_dispense_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PULSE   = 3'd2,
        GAP     = 3'd3,
        PRESENT = 3'd4,
        RETRACT = 3'd5
    } state_t;

    // One shared timer serves both the motor pulse and the present timeout.
    localparam int TMR_MAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int TW = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYC - 1);
`ifdef ATM_RETRACT_EN
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYC);
`endif

    state_t                state_q, state_d;
    logic [NOTE_BITS-1:0]  remaining_q, remaining_d;
    logic [STOCK_BITS-1:0] stock_q, stock_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  req_q;
    logic                  motor_q, motor_d;
    logic                  busy_q;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ret_q, ret_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        stock_d     = stock_q;
        tmr_d       = tmr_q;
        motor_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ret_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.refill) begin
                    stock_d = STOCK_BITS'(STOCK_INIT);
                end else if (bus.req && !req_q && bus.amount != '0) begin
                    remaining_d = bus.amount;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (STOCK_BITS'(remaining_q) > stock_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = PULSE;
                    motor_d = 1'b1;
                    tmr_d   = '0;
                end
            end
            PULSE: begin
                if (tmr_q == P_LAST) begin
                    state_d     = GAP;
                    stock_d     = stock_q - 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                    motor_d = 1'b1;
                end
            end
            GAP: begin
                tmr_d = '0;
                if (remaining_q == '0) begin
                    state_d = PRESENT;
                end else begin
                    state_d = PULSE;
                    motor_d = 1'b1;
                end
            end
            PRESENT: begin
                // taken is checked first so it wins over a coincident timeout
                if (bus.taken) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef ATM_RETRACT_EN
                else begin
                    tmr_d = tmr_q + 1'b1;
                    if (tmr_d == T_END) state_d = RETRACT;
                end
`endif
            end
`ifdef ATM_RETRACT_EN
            RETRACT: begin
                ret_d   = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            stock_q     <= STOCK_BITS'(STOCK_INIT);
            tmr_q       <= '0;
            req_q       <= 1'b0;
            motor_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ret_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            stock_q     <= stock_d;
            tmr_q       <= tmr_d;
            req_q       <= bus.req;
            motor_q     <= motor_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
            err_q       <= err_d;
            ret_q       <= ret_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.motor     = motor_q;
    assign bus.done      = done_q;
    assign bus.err_stock = err_q;
    assign bus.retracted = ret_q;
    assign bus.stock     = stock_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_atm_dispense_ctrl.sv
// tb_atm_dispense_ctrl: directed table-driven and sequence checks for atm_dispense_ctrl.
module tb_atm_dispense_ctrl;
    localparam int PULSE = 2;
    localparam int TMO   = 8;
    localparam int INIT  = 20;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int mstock = INIT;

    atm_dispense_ctrl_if #(.NOTE_BITS(3), .STOCK_BITS(8)) bus ();

    atm_dispense_ctrl #(
        .NOTE_BITS(3), .STOCK_BITS(8), .STOCK_INIT(INIT),
        .PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic       rst;
        logic       req;
        logic [2:0] amt;
        logic       taken;
        logic       refill;
        logic       busy;
        logic       motor;
        logic       done;
        logic       err;
        logic       ret;
        logic [7:0] stock;
        logic [2:0] st;
    } vec_t;

    vec_t tbl [15];

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " state"}, int'(bus.state_dbg), 0);
        chk({nm, " busy"}, int'(bus.busy), 0);
        chk({nm, " motor"}, int'(bus.motor), 0);
        chk({nm, " pulses"}, int'({bus.done, bus.err_stock, bus.retracted}), 0);
    endtask

    // Issues a fresh req edge, follows the whole transaction and checks every cycle
    // until PRESENT (or the error pulse); optionally collects the cash.
    task automatic withdraw(input int amt, input bit take);
        bus.req = 1'b1;
        bus.amount = 3'(amt);
        step();
        bus.req = 1'b0;
        chk("wd check state", int'(bus.state_dbg), 1);
        chk("wd check motor", int'(bus.motor), 0);
        if (amt > mstock) begin
            step();
            chk("err pulse", int'(bus.err_stock), 1);
            chk("err state", int'(bus.state_dbg), 0);
            chk("err motor", int'(bus.motor), 0);
            chk("err stock", int'(bus.stock), mstock);
            step();
            chk("err pulse end", int'(bus.err_stock), 0);
            chk("err motor2", int'(bus.motor), 0);
            return;
        end
        for (int n = 0; n < amt; n++) begin
            for (int p = 0; p < PULSE; p++) begin
                step();
                chk($sformatf("note%0d pulse%0d motor", n, p), int'(bus.motor), 1);
                chk($sformatf("note%0d pulse%0d state", n, p), int'(bus.state_dbg), 2);
            end
            step();
            chk($sformatf("note%0d gap motor", n), int'(bus.motor), 0);
            chk($sformatf("note%0d gap state", n), int'(bus.state_dbg), 3);
            chk($sformatf("note%0d gap stock", n), int'(bus.stock), mstock - n - 1);
        end
        mstock -= amt;
        step();
        chk("present state", int'(bus.state_dbg), 4);
        chk("present busy", int'(bus.busy), 1);
        if (take) begin
            bus.taken = 1'b1;
            step();
            bus.taken = 1'b0;
            chk("done pulse", int'(bus.done), 1);
            chk("done state", int'(bus.state_dbg), 0);
            chk("done busy", int'(bus.busy), 0);
            step();
            chk("done end", int'(bus.done), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst req amt tk rf  busy mot dn er rt stock st
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 20, 0};
        tbl[1]  = '{0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 20, 1};
        tbl[2]  = '{0, 1, 3, 0, 0,  1, 1, 0, 0, 0, 20, 2};
        tbl[3]  = '{0, 1, 3, 0, 0,  1, 1, 0, 0, 0, 20, 2};
        tbl[4]  = '{0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 19, 3};
        tbl[5]  = '{0, 1, 3, 0, 0,  1, 1, 0, 0, 0, 19, 2};
        tbl[6]  = '{0, 1, 3, 0, 0,  1, 1, 0, 0, 0, 19, 2};
        tbl[7]  = '{0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 18, 3};
        tbl[8]  = '{0, 1, 3, 0, 0,  1, 1, 0, 0, 0, 18, 2};
        tbl[9]  = '{0, 1, 3, 0, 0,  1, 1, 0, 0, 0, 18, 2};
        tbl[10] = '{0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 17, 3};
        tbl[11] = '{0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 17, 4};
        tbl[12] = '{0, 1, 3, 1, 0,  0, 0, 1, 0, 0, 17, 0};
        tbl[13] = '{0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 17, 0};
        tbl[14] = '{0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 17, 0};
        bus.req = 1'b0;
        bus.amount = '0;
        bus.taken = 1'b0;
        bus.refill = 1'b0;
        step();

        // reset and a 3-note withdrawal with req held high throughout
        for (int i = 0; i < 15; i++) begin
            reset = tbl[i].rst;
            bus.req = tbl[i].req;
            bus.amount = tbl[i].amt;
            bus.taken = tbl[i].taken;
            bus.refill = tbl[i].refill;
            step();
            chk($sformatf("v%0d busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("v%0d motor", i), int'(bus.motor), int'(tbl[i].motor));
            chk($sformatf("v%0d done", i), int'(bus.done), int'(tbl[i].done));
            chk($sformatf("v%0d err", i), int'(bus.err_stock), int'(tbl[i].err));
            chk($sformatf("v%0d ret", i), int'(bus.retracted), int'(tbl[i].ret));
            chk($sformatf("v%0d stock", i), int'(bus.stock), int'(tbl[i].stock));
            chk($sformatf("v%0d state", i), int'(bus.state_dbg), int'(tbl[i].st));
        end
        mstock = 17;

        // refill then three 7-note requests; the third is rejected
        bus.refill = 1'b1;
        step();
        bus.refill = 1'b0;
        mstock = INIT;
        chk("refill stock", int'(bus.stock), 20);
        withdraw(7, 1'b1);
        chk("stock after 7a", int'(bus.stock), 13);
        withdraw(7, 1'b1);
        chk("stock after 7b", int'(bus.stock), 6);
        withdraw(7, 1'b1);
        chk("stock after 7c", int'(bus.stock), 6);

        // reset during the second note's pulse
        bus.refill = 1'b1;
        step();
        bus.refill = 1'b0;
        mstock = INIT;
        bus.req = 1'b1;
        bus.amount = 3'd3;
        step();
        bus.req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid pulse2 state", int'(bus.state_dbg), 2);
        chk("mid pulse2 motor", int'(bus.motor), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("rst mid");
        chk("rst mid stock", int'(bus.stock), 20);
        step();
        chk_idle("rst after");

        // zero amount is ignored
        bus.req = 1'b1;
        bus.amount = 3'd0;
        step();
        bus.req = 1'b0;
        chk_idle("amt0");
        step();

        // req edge together with refill: refill only
        withdraw(1, 1'b1);
        chk("pre refill stock", int'(bus.stock), 19);
        bus.req = 1'b1;
        bus.amount = 3'd2;
        bus.refill = 1'b1;
        step();
        bus.req = 1'b0;
        bus.refill = 1'b0;
        chk_idle("req+refill");
        chk("req+refill stock", int'(bus.stock), 20);
        step();
        chk_idle("req+refill after");
        mstock = INIT;

`ifdef ATM_RETRACT_EN
        // timeout retract, then taken arriving on the last timer cycle
        withdraw(2, 1'b0);
        for (int k = 1; k < TMO; k++) begin
            step();
            chk($sformatf("wait%0d state", k), int'(bus.state_dbg), 4);
        end
        step();
        chk("retract state", int'(bus.state_dbg), 5);
        chk("retract pulse early", int'(bus.retracted), 0);
        step();
        chk("retracted pulse", int'(bus.retracted), 1);
        chk("retracted no done", int'(bus.done), 0);
        chk("retracted state", int'(bus.state_dbg), 0);
        chk("retracted stock", int'(bus.stock), 18);
        step();
        chk("retracted end", int'(bus.retracted), 0);
        withdraw(1, 1'b0);
        for (int k = 1; k < TMO; k++) step();
        chk("late present", int'(bus.state_dbg), 4);
        bus.taken = 1'b1;
        step();
        bus.taken = 1'b0;
        chk("late take done", int'(bus.done), 1);
        chk("late take no ret", int'(bus.retracted), 0);
        chk("late take state", int'(bus.state_dbg), 0);
`else
        // no retract: PRESENT waits indefinitely
        withdraw(1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            step();
            chk($sformatf("hold%0d state", k), int'(bus.state_dbg), 4);
            chk($sformatf("hold%0d ret", k), int'(bus.retracted), 0);
        end
        bus.taken = 1'b1;
        step();
        bus.taken = 1'b0;
        chk("hold take done", int'(bus.done), 1);
        chk("hold take state", int'(bus.state_dbg), 0);
        chk("hold take stock", int'(bus.stock), 19);
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
